// File: rtl/aftab_wb_pkg.sv
// Shared constants for the AFTAB execute-stage result buffer: source
// select encodings and the writeback skid-buffer depth.
package aftab_wb_pkg;

    localparam logic [1:0] SEL_LLU   = 2'b00;
    localparam logic [1:0] SEL_ADD   = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam logic [1:0] SEL_CMP   = 2'b11;

    localparam int WB_DEPTH = 2;

endpackage

// File: rtl/aftab_result_mux.sv
// Combinational 4:1 select of the execute-unit results. The comparator
// delivers a single set-less-than bit, zero-extended to the datapath width.
module aftab_result_mux
    import aftab_wb_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [1:0]      selResult,
    input  logic [size-1:0] lluResult,
    input  logic [size-1:0] addResult,
    input  logic [size-1:0] shiftResult,
    input  logic            cmpResult,
    output logic [size-1:0] result
);

    // Pick the execute result named by selResult.
    always_comb begin
        result = '0;
        case (selResult)
            SEL_LLU:   result = lluResult;
            SEL_ADD:   result = addResult;
            SEL_SHIFT: result = shiftResult;
            SEL_CMP:   result = {{(size-1){1'b0}}, cmpResult};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/aftab_exe_result_buffer.sv
// Execute-stage result collector: selects one execute result, tags it with
// its destination register and holds it in a 2-entry skid FIFO feeding
// register-file writeback.
//
// Optional build macro AFTAB_WB_X0_SUPPRESS_EN: when defined, a push whose
// rdIn is 0 completes its handshake but is dropped, so x0 writes never
// reach writeback.
//
// Handshake: a push happens on any cycle with inValid && inReady, a pop on
// any cycle with outValid && outReady; data transfers on the rising edge
// ending that cycle. inReady depends only on the registered count, never on
// outReady, so a writeback stall cannot ripple back combinationally.
module aftab_exe_result_buffer
    import aftab_wb_pkg::*;
#(
    parameter int size    = 32,
    parameter int rdWidth = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               inValid,
    output logic               inReady,
    input  logic [1:0]         selResult,
    input  logic [size-1:0]    lluResult,
    input  logic [size-1:0]    addResult,
    input  logic [size-1:0]    shiftResult,
    input  logic               cmpResult,
    input  logic [rdWidth-1:0] rdIn,
    output logic               outValid,
    input  logic               outReady,
    output logic [size-1:0]    wbData,
    output logic [rdWidth-1:0] wbRd
);

    localparam logic [1:0] COUNT_FULL = 2'(WB_DEPTH);

    logic [size-1:0]    data_q [WB_DEPTH];
    logic [rdWidth-1:0] rd_q   [WB_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;

    logic [size-1:0]    sel_data;
    logic               push;
    logic               pop;
    logic               enq;

    aftab_result_mux #(
        .size(size)
    ) u_result_mux (
        .selResult  (selResult),
        .lluResult  (lluResult),
        .addResult  (addResult),
        .shiftResult(shiftResult),
        .cmpResult  (cmpResult),
        .result     (sel_data)
    );

    assign inReady  = (count != COUNT_FULL);
    assign outValid = (count != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

`ifdef AFTAB_WB_X0_SUPPRESS_EN
    assign enq = push && (rdIn != '0);
`else
    assign enq = push;
`endif

    // Every entry is zeroed when it is popped or flushed, so the slot at the
    // read pointer is always zero while the buffer is empty and the outputs
    // can be taken straight from it.
    assign wbData = data_q[rd_ptr];
    assign wbRd   = rd_q[rd_ptr];

    // FIFO storage, pointers and occupancy; rst and flush both empty it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // A pop and a push in the same cycle always hit different slots:
            // a pop needs count>=1 and a push needs count<=1.
            if (pop) begin
                data_q[rd_ptr] <= '0;
                rd_q[rd_ptr]   <= '0;
                rd_ptr         <= ~rd_ptr;
            end
            if (enq) begin
                data_q[wr_ptr] <= sel_data;
                rd_q[wr_ptr]   <= rdIn;
                wr_ptr         <= ~wr_ptr;
            end
            case ({enq, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
